fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction queue between the fetch stage and decode. It captures each instruction and PC the fetch stage delivers, and buffers up to DEPTH entries. Entries are presented to decode in order with a valid/ready handshake, and the queue applies back-pressure to fetch when it is full. A branch/jump redirect flushes the queue so that wrong-path instructions never reach decode.

## Interface
- XLEN, 32, instruction data width
- ADDR_WIDTH, 32, PC width
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-high reset
- flush_i  input  1  redirect; discard all entries (driven from execute branch_taken)
- enq_valid_i  input  1  fetch delivers an instruction this cycle (fetch instr_valid)
- enq_pc_i  input  ADDR_WIDTH  PC of delivered instruction
- enq_instr_i  input  XLEN  delivered instruction word
- full_o  output  1  queue full; drives fetch stall input
- deq_valid_o  output  1  head entry valid for decode
- deq_pc_o  output  ADDR_WIDTH  head PC
- deq_instr_o  output  XLEN  head instruction
- deq_ready_i  input  1  decode accepts head this cycle
- count_o  output  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH-entry circular buffer of {pc, instr}, with write and read pointers of $clog2(DEPTH)+1 bits each. The extra MSB distinguishes full from empty.
- count = wr_ptr − rd_ptr (modulo 2^(ptr width)). full_o = (count == DEPTH). deq_valid_o = (count != 0).
- Enqueue fires when enq_valid_i && !full_o && !flush_i. The entry is written at wr_ptr[low bits] and wr_ptr increments; low bits wrap from DEPTH−1 to 0.
- enq_valid_i while full_o=1 is a protocol violation. The entry is dropped and the queue state is unchanged; a FORMAL assertion covers this.
- Dequeue fires when deq_valid_o && deq_ready_i && !flush_i, and rd_ptr increments.
- Simultaneous enqueue and dequeue: both fire and count is unchanged. When full, an enqueue is still refused even if a dequeue fires in the same cycle; full_o does not look ahead.
- First-word fall-through: deq_pc_o and deq_instr_o are driven from the head entry whenever deq_valid_o=1.
- When deq_valid_o=0, deq_instr_o = 32'h00000013 (NOP) and deq_pc_o = 0.
- Flush has priority over everything: wr_ptr and rd_ptr are set to 0 at the next edge, and any enqueue or dequeue in the flush cycle is discarded.
- Storage contents are not cleared by reset or flush; only the pointers are.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release): pointers = 0, count_o = 0, full_o = 0, deq_valid_o = 0, deq_instr_o = 0x00000013, deq_pc_o = 0.
- Reset asserted mid-operation empties the queue immediately, without waiting for a clock edge.
- Enqueue-to-visible latency is 1 cycle: an entry enqueued at edge N has deq_valid_o=1 and its data at the outputs during cycle N+1.
- Throughput is 1 entry/cycle in steady state with simultaneous enqueue and dequeue.
- full_o and deq_valid_o are functions of registered pointers only, with no combinational path from enq_valid_i or deq_ready_i.
- Flush at edge N: during cycle N+1, count_o = 0, deq_valid_o = 0, full_o = 0. An enqueue is accepted normally in cycle N+1.
- Back-pressure: full_o rises in the cycle after the DEPTH-th enqueue. It falls in the cycle after the first dequeue from full.

## Test plan
- Reset, then 4 enqueues with PCs 0x0, 0x4, 0x8, 0xC and deq_ready_i=0. Required: count_o steps 1..4 and full_o=1 after the 4th. A 5th enqueue attempt leaves count_o=4 and the head remains PC 0x0.
- Drain from full with deq_ready_i=1. Required: decode sees PCs 0x0, 0x4, 0x8, 0xC, one per cycle. Then deq_valid_o=0, deq_instr_o=0x00000013, count_o=0.
- Continuous streaming of 20 instructions (PC 0x100 + 4k) with deq_ready_i=1. Required: each appears 1 cycle after enqueue, in order, count_o ≤ 1, and pointer wrap-around is exercised.
- 3 entries buffered, then flush_i=1 coincident with enq_valid_i=1 (PC 0x200) and deq_ready_i=1. Required next cycle: count_o=0, deq_valid_o=0, and PC 0x200 is absent. An enqueue of PC 0x40 on the following cycle appears at the head.
- Full queue with simultaneous enq_valid_i=1 and deq_ready_i=1. Required: head dequeued, new entry refused, count_o=3 next cycle.
- rst_i asserted asynchronously between clock edges with 2 entries queued. Required: deq_valid_o=0 and count_o=0 before the next rising edge, and the queue is empty after release.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue interface: fetch enqueue side, decode dequeue side, flush and status.
interface fetch_queue_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
);
  logic                         flush_i;
  logic                         enq_valid_i;
  logic [ADDR_WIDTH-1:0]        enq_pc_i;
  logic [XLEN-1:0]              enq_instr_i;
  logic                         full_o;
  logic                         deq_valid_o;
  logic [ADDR_WIDTH-1:0]        deq_pc_o;
  logic [XLEN-1:0]              deq_instr_o;
  logic                         deq_ready_i;
  logic [$clog2(DEPTH+1)-1:0]   count_o;

  modport master (
    output flush_i, enq_valid_i, enq_pc_i, enq_instr_i, deq_ready_i,
    input  full_o, deq_valid_o, deq_pc_o, deq_instr_o, count_o
  );

  modport slave (
    input  flush_i, enq_valid_i, enq_pc_i, enq_instr_i, deq_ready_i,
    output full_o, deq_valid_o, deq_pc_o, deq_instr_o, count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: circular buffer with FWFT head and flush on redirect.
module fetch_queue #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_pc_mem    [DEPTH];
  logic [XLEN-1:0]       r_instr_mem [DEPTH];

  logic [PW-1:0] w_count;
  logic          w_full;
  logic          w_valid;
  logic          w_enq;
  logic          w_deq;

  // Status depends only on registered pointers; the extra MSB separates full from empty.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == PW'(DEPTH));
  assign w_valid = (w_count != '0);
  assign w_enq   = q.enq_valid_i && !w_full && !q.flush_i;
  assign w_deq   = w_valid && q.deq_ready_i && !q.flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (q.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_pc_mem[r_wr_ptr[IW-1:0]]    <= q.enq_pc_i;
      r_instr_mem[r_wr_ptr[IW-1:0]] <= q.enq_instr_i;
    end
  end

  assign q.count_o     = w_count;
  assign q.full_o      = w_full;
  assign q.deq_valid_o = w_valid;
  assign q.deq_pc_o    = w_valid ? r_pc_mem[r_rd_ptr[IW-1:0]] : '0;
  assign q.deq_instr_o = w_valid ? r_instr_mem[r_rd_ptr[IW-1:0]] : XLEN'(32'h0000_0013);

  // An enqueue offered while full must leave the write pointer untouched.
  a_enq_when_full: assert property (
    @(posedge clk_i) disable iff (rst_i)
      (q.enq_valid_i && w_full && !q.flush_i) |=> (r_wr_ptr == $past(r_wr_ptr))
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32), .ADDR_WIDTH(32), .DEPTH(4)) fq ();

  fetch_queue #(.XLEN(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .q     (fq.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    fq.enq_valid_i = v;
    fq.enq_pc_i    = pc;
    fq.enq_instr_i = 32'hA000_0000 | pc;
    fq.deq_ready_i = rdy;
    fq.flush_i     = fl;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", fq.count_o, 0);
    chk("rst_full",  fq.full_o, 0);
    chk("rst_valid", fq.deq_valid_o, 0);
    chk("rst_instr", fq.deq_instr_o, 32'h13);
    chk("rst_pc",    fq.deq_pc_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Fill to full with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
      tick();
      chk("fill_count", fq.count_o, 64'(i + 1));
      chk("fill_full", fq.full_o, (i == 3) ? 64'd1 : 64'd0);
    end
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    tick();
    chk("ovf_count", fq.count_o, 4);
    chk("ovf_head",  fq.deq_pc_o, 0);
    chk("ovf_full",  fq.full_o, 1);

    // Drain from full
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", fq.deq_valid_o, 1);
      chk("drain_pc", fq.deq_pc_o, 64'(4 * i));
      chk("drain_instr", fq.deq_instr_o, 64'(32'hA000_0000 | 32'(4 * i)));
      tick();
      if (i == 0) chk("drain_full_fall", fq.full_o, 0);
    end
    chk("drain_valid_end", fq.deq_valid_o, 0);
    chk("drain_nop", fq.deq_instr_o, 32'h13);
    chk("drain_pc_end", fq.deq_pc_o, 0);
    chk("drain_count_end", fq.count_o, 0);

    // Streaming with wrap-around
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 1'b1, 1'b0);
      tick();
      chk("stream_valid", fq.deq_valid_o, 1);
      chk("stream_pc", fq.deq_pc_o, 64'(32'h100 + 32'(4 * k)));
      chk("stream_count", fq.count_o, 1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("stream_empty", fq.count_o, 0);

    // Flush with coincident enqueue/dequeue
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    chk("pre_flush_count", fq.count_o, 3);
    drive(1'b1, 32'h200, 1'b1, 1'b1);
    tick();
    chk("flush_count", fq.count_o, 0);
    chk("flush_valid", fq.deq_valid_o, 0);
    chk("flush_full",  fq.full_o, 0);
    chk("flush_pc",    fq.deq_pc_o, 0);
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    tick();
    chk("post_flush_valid", fq.deq_valid_o, 1);
    chk("post_flush_pc", fq.deq_pc_o, 32'h40);
    chk("post_flush_count", fq.count_o, 1);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("post_flush_empty", fq.count_o, 0);

    // Full with simultaneous enqueue and dequeue
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    chk("full2_full", fq.full_o, 1);
    drive(1'b1, 32'h600, 1'b1, 1'b0);
    tick();
    chk("full2_count", fq.count_o, 3);
    chk("full2_head", fq.deq_pc_o, 32'h504);
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      chk("full2_drain_pc", fq.deq_pc_o, 64'(32'h500 + 32'(4 * i)));
      tick();
    end
    chk("full2_refused", fq.count_o, 0);

    // Asynchronous reset between edges
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h700 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("pre_arst_count", fq.count_o, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", fq.deq_valid_o, 0);
    chk("arst_count", fq.count_o, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_arst_count", fq.count_o, 0);
    chk("post_arst_valid", fq.deq_valid_o, 0);
    drive(1'b1, 32'h800, 1'b0, 1'b0);
    tick();
    chk("post_arst_enq_pc", fq.deq_pc_o, 32'h800);
    drive(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
